// File: rtl/pulse_period_checker_if.sv
// Strobe-train checker bundle: pulse in, lock/period/phase/error status out.
// Ports: pulse (master->slave); locked, period, period_valid, phase, err_early, err_late (slave->master).
interface pulse_period_checker_if #(
   parameter int unsigned PW = 3
);
   logic          pulse;
   logic          locked;
   logic [PW-1:0] period;
   logic          period_valid;
   logic [PW-1:0] phase;
   logic          err_early;
   logic          err_late;

   modport master (
      output pulse,
      input  locked, period, period_valid, phase, err_early, err_late
   );

   modport slave (
      input  pulse,
      output locked, period, period_valid, phase, err_early, err_late
   );
endinterface

// File: rtl/pulse_period_checker.sv
// Measures the interval between 1-cycle strobes, checks it against BEATS,
// flags early/late strobes and asserts locked after LOCK_COUNT good intervals.
// Ports: clk, reset (sync, active-high), bus (slave: pulse in; status out).
module pulse_period_checker #(
   parameter int unsigned BEATS      = 2,
   parameter int unsigned LOCK_COUNT = 4
) (
   input logic                   clk,
   input logic                   reset,
   pulse_period_checker_if.slave bus
);
   localparam int unsigned PW = $clog2(2*BEATS+2);
   localparam int unsigned MW = $clog2(LOCK_COUNT+1);
   localparam logic [PW-1:0] CNT_MAX = '1;
   localparam logic [PW-1:0] BEATS_C = PW'(BEATS);
   localparam logic [MW-1:0] LOCK_C  = MW'(LOCK_COUNT);

   typedef enum logic [1:0] {
      IDLE,
      ACQUIRE,
      LOCKED
   } state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] period_q, period_d;
   logic [MW-1:0] match_q, match_d;
   logic          locked_q, locked_d;
   logic          pv_q, pv_d;
   logic          early_q, early_d;
   logic          late_q, late_d;

   logic active;
   logic hit;
   logic early;
   logic late;

   always_comb begin
      active = (state_q != IDLE);
      hit    = active && bus.pulse && (cnt_q == BEATS_C);
      early  = active && bus.pulse && (cnt_q < BEATS_C);
      // cnt passes BEATS exactly once per gap, so late fires only once
      late   = active && !bus.pulse && (cnt_q == BEATS_C);

      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      match_d  = match_q;
      pv_d     = 1'b0;
      early_d  = early;
      late_d   = late;

      if (bus.pulse) begin
         cnt_d = PW'(1);
      end else if (active && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end

      if (bus.pulse && active) begin
         period_d = cnt_q;
         pv_d     = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (bus.pulse) begin
               state_d = ACQUIRE;
               match_d = '0;
            end
         end
         ACQUIRE: begin
            if (early || late) begin
               match_d = '0;
            end else if (hit) begin
               match_d = match_q + 1'b1;
               if (match_d == LOCK_C) begin
                  state_d = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (early || late) begin
               state_d = ACQUIRE;
               match_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            match_d = '0;
         end
      endcase

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         period_q <= '0;
         match_q  <= '0;
         locked_q <= 1'b0;
         pv_q     <= 1'b0;
         early_q  <= 1'b0;
         late_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         match_q  <= match_d;
         locked_q <= locked_d;
         pv_q     <= pv_d;
         early_q  <= early_d;
         late_q   <= late_d;
      end
   end

   assign bus.locked       = locked_q;
   assign bus.period       = period_q;
   assign bus.period_valid = pv_q;
   assign bus.phase        = cnt_q;
   assign bus.err_early    = early_q;
   assign bus.err_late     = late_q;

endmodule
